// File: rtl/riscv_pkg.sv
// Shared pipeline-control definitions: forwarding selects, hazard FSM states, x0 index.
// Used by the hazard unit and its operand forwarding selector.
package riscv_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {
    IDLE       = 1'b0,
    LOAD_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/forward_sel.sv
// Operand forwarding select for one execute-stage source register.
// Purely combinational, zero latency; no flow control.
module forward_sel
  import riscv_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       we_m,
  input  logic [4:0] rd_w,
  input  logic       we_w,
  output logic [1:0] sel
);

  logic live;

  assign live = (rs != REG_X0);

  // The newer (MEM) result shadows the older (WB) one.
  always_comb begin
    sel = FWD_RF;
    if (live && we_m && (rs == rd_m)) begin
      sel = FWD_MEM;
    end else if (live && we_w && (rs == rd_w)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, load-use stall and branch-flush control for execute and ID/EX.
// Controls are combinational from state and inputs; stall/flush event counters saturate.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             ctrl_register_file_WE_E,
  input  logic             ctrl_register_file_WE_M,
  input  logic             ctrl_register_file_WE_W,
  input  logic             ctrl_result_E,
  input  logic             branch_taken_E,
  output logic [1:0]       forward_A_E,
  output logic [1:0]       forward_B_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] BUB_INIT = 3'(LOAD_LATENCY - 1);

  hz_state_t  state, state_nxt;
  logic [2:0] bub, bub_nxt;
  logic [1:0] sel_a, sel_b;
  logic       load_use;

  forward_sel u_fwd_a (
    .rs   (rs1_E),
    .rd_m (rd_M),
    .we_m (ctrl_register_file_WE_M),
    .rd_w (rd_W),
    .we_w (ctrl_register_file_WE_W),
    .sel  (sel_a)
  );

  forward_sel u_fwd_b (
    .rs   (rs2_E),
    .rd_m (rd_M),
    .we_m (ctrl_register_file_WE_M),
    .rd_w (rd_W),
    .we_w (ctrl_register_file_WE_W),
    .sel  (sel_b)
  );

  assign load_use = ctrl_result_E && ctrl_register_file_WE_E && (rd_E != REG_X0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  always_comb begin
    state_nxt   = state;
    bub_nxt     = bub;
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    forward_A_E = FWD_RF;
    forward_B_E = FWD_RF;
    if (!rst_n) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else begin
      forward_A_E = sel_a;
      forward_B_E = sel_b;
      case (state)
        IDLE: begin
          // A taken branch squashes the decode instruction, so its load-use is moot.
          if (branch_taken_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
          end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
            if (LOAD_LATENCY > 1) begin
              state_nxt = LOAD_STALL;
              bub_nxt   = BUB_INIT;
            end
          end
        end
        LOAD_STALL: begin
          if (branch_taken_E) begin
            flush_D   = 1'b1;
            flush_E   = 1'b1;
            state_nxt = IDLE;
            bub_nxt   = 3'd0;
          end else begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
            bub_nxt = bub - 3'd1;
            if (bub == 3'd1) begin
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          bub_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bub         <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      bub   <= bub_nxt;
      if (stall_D && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
      if (branch_taken_E && flush_D && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboarded bench: four hazard_unit instances (different latencies, one narrow counter)
// share one stimulus stream and are checked against a per-instance behavioural model.
module tb_hazard_unit;

  localparam int NDUT = 4;
  localparam int LLS [NDUT] = '{1, 3, 4, 2};
  localparam int CWS [NDUT] = '{32, 32, 32, 4};

  typedef struct packed {
    logic        rst_n;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        we_e, we_m, we_w, res_e, br;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        sf, sd, fd, fe;
    logic [31:0] sc, fc;
  } exp_t;

  typedef exp_t [NDUT-1:0] exp4_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic        we_E, we_M, we_W, res_E, br_E;

  logic [1:0]  fa [NDUT];
  logic [1:0]  fb [NDUT];
  logic        sf [NDUT];
  logic        sd [NDUT];
  logic        fd [NDUT];
  logic        fe [NDUT];
  logic [31:0] sc [NDUT];
  logic [31:0] fc [NDUT];

  exp4_t       sb_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          running = 0;

  int          bub_m [NDUT];
  longint      sc_m  [NDUT];
  longint      fc_m  [NDUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [CWS[g]-1:0] sc_l, fc_l;
    hazard_unit #(.LOAD_LATENCY(LLS[g]), .CNT_W(CWS[g])) u_dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .rs1_D                   (rs1_D),
      .rs2_D                   (rs2_D),
      .rs1_E                   (rs1_E),
      .rs2_E                   (rs2_E),
      .rd_E                    (rd_E),
      .rd_M                    (rd_M),
      .rd_W                    (rd_W),
      .ctrl_register_file_WE_E (we_E),
      .ctrl_register_file_WE_M (we_M),
      .ctrl_register_file_WE_W (we_W),
      .ctrl_result_E           (res_E),
      .branch_taken_E          (br_E),
      .forward_A_E             (fa[g]),
      .forward_B_E             (fb[g]),
      .stall_F                 (sf[g]),
      .stall_D                 (sd[g]),
      .flush_D                 (fd[g]),
      .flush_E                 (fe[g]),
      .stall_count             (sc_l),
      .flush_count             (fc_l)
    );
    assign sc[g] = 32'(sc_l);
    assign fc[g] = 32'(fc_l);
  end

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input stim_t s);
    if (rs != 0 && s.we_m && rs == s.rd_m) return 2'b10;
    if (rs != 0 && s.we_w && rs == s.rd_w) return 2'b01;
    return 2'b00;
  endfunction

  // Drive one cycle of inputs, record what every instance should show, advance the model.
  task automatic apply(input stim_t s);
    exp4_t  e;
    bit     lu;
    longint cmax;
    rst_n = s.rst_n; rs1_D = s.rs1_d; rs2_D = s.rs2_d; rs1_E = s.rs1_e; rs2_E = s.rs2_e;
    rd_E = s.rd_e; rd_M = s.rd_m; rd_W = s.rd_w;
    we_E = s.we_e; we_M = s.we_m; we_W = s.we_w; res_E = s.res_e; br_E = s.br;
    lu = s.res_e && s.we_e && s.rd_e != 0 && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
    for (int i = 0; i < NDUT; i++) begin
      cmax = (64'd1 << CWS[i]) - 1;
      e[i] = '0;
      e[i].sc = 32'(sc_m[i]);
      e[i].fc = 32'(fc_m[i]);
      if (!s.rst_n) begin
        e[i].fd = 1'b1;
        e[i].fe = 1'b1;
        bub_m[i] = 0; sc_m[i] = 0; fc_m[i] = 0;
      end else begin
        e[i].fa = fwd_ref(s.rs1_e, s);
        e[i].fb = fwd_ref(s.rs2_e, s);
        if (s.br) begin
          e[i].fd = 1'b1;
          e[i].fe = 1'b1;
          bub_m[i] = 0;
          if (fc_m[i] < cmax) fc_m[i]++;
        end else if (bub_m[i] > 0 || lu) begin
          e[i].sf = 1'b1;
          e[i].sd = 1'b1;
          e[i].fe = 1'b1;
          bub_m[i] = (bub_m[i] > 0) ? bub_m[i] - 1 : LLS[i] - 1;
          if (sc_m[i] < cmax) sc_m[i]++;
        end
      end
    end
    sb_q.push_back(e);
    running = 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (running) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cyc=%0d got no expectation, need one per cycle", cyc);
      end else begin
        exp4_t e;
        e = sb_q.pop_front();
        for (int i = 0; i < NDUT; i++) begin
          exp_t a;
          a = '{fa: fa[i], fb: fb[i], sf: sf[i], sd: sd[i], fd: fd[i], fe: fe[i],
                sc: sc[i], fc: fc[i]};
          if (i > 0) checks++;
          if (a !== e[i]) begin
            errors++;
            $display("FAIL dut%0d_outputs cyc=%0d got fa=%b fb=%b sF=%b sD=%b fD=%b fE=%b sc=%0d fc=%0d exp fa=%b fb=%b sF=%b sD=%b fD=%b fE=%b sc=%0d fc=%0d",
                     i, cyc, a.fa, a.fb, a.sf, a.sd, a.fd, a.fe, a.sc, a.fc,
                     e[i].fa, e[i].fb, e[i].sf, e[i].sd, e[i].fd, e[i].fe, e[i].sc, e[i].fc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d got no finish, need finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    stim_t idle, s;
    idle = '{rst_n: 1'b1, default: '0};
    for (int i = 0; i < NDUT; i++) begin
      bub_m[i] = 0; sc_m[i] = 0; fc_m[i] = 0;
    end
    rst_n = 0; rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    we_E = 0; we_M = 0; we_W = 0; res_E = 0; br_E = 0;
    @(posedge clk);
    #1;

    // Reset held: forced outputs, counters cleared.
    s = idle; s.rst_n = 0; apply(s); apply(s);

    // Forwarding priority and x0.
    s = idle; s.rs1_e = 5; s.rs2_e = 5; s.rd_m = 5; s.we_m = 1; s.rd_w = 5; s.we_w = 1; apply(s);
    s.we_m = 0; apply(s);
    s.rs1_e = 0; s.rd_m = 0; s.we_m = 1; apply(s);
    s = idle; s.rs2_e = 7; s.rd_m = 6; s.we_m = 1; s.rd_w = 7; s.we_w = 1; apply(s);

    // Single load-use hazard, then quiet until the longest latency drains.
    s = idle; s.rd_e = 3; s.res_e = 1; s.we_e = 1; s.rs2_d = 3; apply(s);
    for (int k = 0; k < 5; k++) apply(idle);

    // Taken branch together with a load-use: branch wins.
    s = idle; s.rd_e = 3; s.res_e = 1; s.we_e = 1; s.rs1_d = 3; s.br = 1; apply(s);
    apply(idle); apply(idle);

    // Branch arriving in the middle of a multi-cycle stall aborts it.
    s = idle; s.rd_e = 4; s.res_e = 1; s.we_e = 1; s.rs1_d = 4; apply(s);
    s = idle; s.br = 1; apply(s);
    for (int k = 0; k < 4; k++) apply(idle);

    // Reset dropped in the second stall cycle discards remaining bubbles.
    s = idle; s.rd_e = 9; s.res_e = 1; s.we_e = 1; s.rs2_d = 9; apply(s);
    s = idle; s.rst_n = 0; apply(s);
    for (int k = 0; k < 5; k++) apply(idle);

    // Hazard held for 20+ cycles: the 4-bit counter saturates at 15.
    s = idle; s.rd_e = 2; s.res_e = 1; s.we_e = 1; s.rs1_d = 2;
    for (int k = 0; k < 24; k++) apply(s);
    for (int k = 0; k < 5; k++) apply(idle);

    // Randomised traffic over a small register set to provoke collisions.
    for (int k = 0; k < 3000; k++) begin
      s.rst_n = ($urandom_range(0, 59) != 0);
      s.rs1_d = 5'($urandom_range(0, 3));
      s.rs2_d = 5'($urandom_range(0, 3));
      s.rs1_e = 5'($urandom_range(0, 3));
      s.rs2_e = 5'($urandom_range(0, 3));
      s.rd_e  = 5'($urandom_range(0, 3));
      s.rd_m  = 5'($urandom_range(0, 3));
      s.rd_w  = 5'($urandom_range(0, 3));
      s.we_e  = 1'($urandom_range(0, 1));
      s.we_m  = 1'($urandom_range(0, 1));
      s.we_w  = 1'($urandom_range(0, 1));
      s.res_e = 1'($urandom_range(0, 1));
      s.br    = ($urandom_range(0, 9) == 0);
      apply(s);
    end

    running = 0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d leftover entries, need 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline control block that drives the execute stage and the ID/EX stage register. It generates operand-forwarding selects for execute and stall/flush controls for fetch, decode and the ID/EX register. It inserts a parameterised number of bubbles on load-use hazards and flushes on taken branches. It also keeps saturating stall and flush event counters for performance debug.

Parameters:
LOAD_LATENCY, 1, bubbles inserted per load-use hazard; legal range 1..4.
CNT_W, 32, width of each event counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
rs1_D  input  5  decode-stage source register 1
rs2_D  input  5  decode-stage source register 2
rs1_E  input  5  execute-stage source register 1
rs2_E  input  5  execute-stage source register 2
rd_E  input  5  execute-stage destination register
rd_M  input  5  memory-stage destination register
rd_W  input  5  writeback-stage destination register
ctrl_register_file_WE_E  input  1  execute-stage instruction writes register file
ctrl_register_file_WE_M  input  1  memory-stage instruction writes register file
ctrl_register_file_WE_W  input  1  writeback-stage instruction writes register file
ctrl_result_E  input  1  execute-stage result comes from data memory (load)
branch_taken_E  input  1  branch/jump resolved taken in execute
forward_A_E  output  2  srcA operand select
forward_B_E  output  2  srcB operand select
stall_F  output  1  hold PC
stall_D  output  1  hold IF/ID register
flush_D  output  1  clear IF/ID register
flush_E  output  1  clear ID/EX register (insert bubble)
stall_count  output  CNT_W  cycles with stall_D=1
flush_count  output  CNT_W  taken-branch flush events

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset: state=IDLE, bubble counter=0, stall_count=0, flush_count=0.
  - While rst_n=0, the outputs are forced as follows: flush_D=1, flush_E=1, stall_F=0, stall_D=0, forward_A_E=00, forward_B_E=00.
- Forwarding is combinational with zero latency. For operand A (B is identical using rs2_E):
  - 10 (from MEM) if rs1_E!=0, WE_M=1 and rs1_E==rd_M.
  - Otherwise 01 (from WB) if rs1_E!=0, WE_W=1 and rs1_E==rd_W.
  - Otherwise 00 (from register file).
  - MEM takes priority over WB. Register x0 never forwards.
- load_use = ctrl_result_E & WE_E & (rd_E!=0) & ((rd_E==rs1_D) | (rd_E==rs2_D)).
- FSM states are IDLE and LOAD_STALL. All control outputs are Mealy/combinational from the state and the current inputs.
- IDLE:
  - If branch_taken_E: flush_D=1 and flush_E=1 in the same cycle, no stall, stay IDLE. Branch wins over a simultaneous load_use, because the decode instruction is squashed.
  - Else if load_use: stall_F=1, stall_D=1, flush_E=1.
    - If LOAD_LATENCY==1, stay IDLE.
    - Otherwise load counter=LOAD_LATENCY-1 and go to LOAD_STALL.
  - Else all controls are 0.
- LOAD_STALL:
  - stall_F=1, stall_D=1, flush_E=1. Decrement the counter each cycle.
  - Go to IDLE on the cycle the counter reads 1. Total bubbles per hazard = LOAD_LATENCY.
  - If branch_taken_E is asserted here (a protocol violation), abort: flush_D=1, flush_E=1, stall=0, go to IDLE.
- stall_count: +1 on every cycle with stall_D=1. Saturates at all-ones; no wrap.
- flush_count: +1 on every cycle with branch_taken_E=1 that produces flush_D. Saturates at all-ones.
- Reset asserted mid-stall: the next cycle is IDLE and any remaining bubbles are discarded.

Decomposition:
- Shared package riscv_pkg holds:
  - forward encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the hazard FSM state enum;
  - the x0 register index constant.
- One sub-module, forward_sel, is instantiated twice (operands A and B). Its inputs are rs, rd_M, WE_M, rd_W, WE_W; its output is the 2-bit select.

Test Plan:
- Forwarding priority: rs1_E=5, rd_M=5, WE_M=1, rd_W=5, WE_W=1 -> forward_A_E=10. Drop WE_M -> 01. Set rs1_E=0 with matching rd_M -> 00.
- Load-use, LOAD_LATENCY=1: rd_E=3, ctrl_result_E=1, WE_E=1, rs2_D=3 -> exactly one cycle of stall_F=stall_D=flush_E=1; stall_count goes 0 to 1.
- Load-use, LOAD_LATENCY=3: same hazard -> three consecutive stall cycles, then controls 0; stall_count=3.
- Taken branch simultaneous with load-use: branch_taken_E=1 and load_use true -> flush_D=flush_E=1, stall_F=0; flush_count=1, stall_count unchanged.
- Reset mid-stall (LOAD_LATENCY=4): drop rst_n in the 2nd stall cycle -> forced outputs while rst_n=0. After release: IDLE, no residual stall, counters=0.
- Saturation, CNT_W=4: 20 consecutive load-use stalls -> stall_count holds at 15.
